// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Capture stage for the ALU result bus. Each accepted result is stored with
//   its opcode tag in a small first-word-fall-through FIFO, so the head entry
//   is visible on out_* without a read strobe.
//
//   Optional macro ALU_RES_FIFO_FLAGS_EN: when defined, zero/negative flags
//   are computed at push time and stored per entry. When undefined, no flag
//   storage exists and out_zero/out_neg are tied low.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   in_valid/in_ready  producer handshake (in_ready = not full)
//   in_res, in_op      result and opcode tag to store
//   out_valid/out_ready consumer handshake (out_valid = not empty)
//   out_res, out_op    head entry, driven combinationally
//   out_zero, out_neg  head entry flags (0 unless flags are enabled)
//   count              occupancy, 0..DEPTH
//   ovf_err            sticky: push attempted while full
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int OPW   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_res,
  input  logic [OPW-1:0]           in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_res,
  output logic [OPW-1:0]           out_op,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] res_mem_q [DEPTH];
  logic [WIDTH-1:0] res_mem_d [DEPTH];
  logic [OPW-1:0]   op_mem_q  [DEPTH];
  logic [OPW-1:0]   op_mem_d  [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_err_q, ovf_err_d;

  logic push, pop;

  // Handshake outputs depend only on registered occupancy, so a pop at full
  // never opens a same-cycle push.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    res_mem_d = res_mem_q;
    op_mem_d  = op_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_err_d = ovf_err_q | (in_valid && !in_ready);
    if (push) begin
      res_mem_d[wr_ptr_q] = in_res;
      op_mem_d[wr_ptr_q]  = in_op;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_mem_q[i] <= '0;
        op_mem_q[i]  <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      res_mem_q <= res_mem_d;
      op_mem_q  <= op_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  assign out_res = res_mem_q[rd_ptr_q];
  assign out_op  = op_mem_q[rd_ptr_q];
  assign count   = count_q;
  assign ovf_err = ovf_err_q;

`ifdef ALU_RES_FIFO_FLAGS_EN
  logic zero_mem_q [DEPTH];
  logic zero_mem_d [DEPTH];
  logic neg_mem_q  [DEPTH];
  logic neg_mem_d  [DEPTH];

  always_comb begin
    zero_mem_d = zero_mem_q;
    neg_mem_d  = neg_mem_q;
    if (push) begin
      zero_mem_d[wr_ptr_q] = (in_res == '0);
      neg_mem_d[wr_ptr_q]  = in_res[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        zero_mem_q[i] <= 1'b0;
        neg_mem_q[i]  <= 1'b0;
      end
    end else begin
      zero_mem_q <= zero_mem_d;
      neg_mem_q  <= neg_mem_d;
    end
  end

  assign out_zero = zero_mem_q[rd_ptr_q];
  assign out_neg  = neg_mem_q[rd_ptr_q];
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

`ifdef ALU_RES_FIFO_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_res;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_res;
  logic [2:0] out_op;
  logic       out_zero;
  logic       out_neg;
  logic [2:0] count;
  logic       ovf_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.WIDTH(4), .DEPTH(4), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg), .count(count), .ovf_err(ovf_err)
  );

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] r, input logic [2:0] o);
    in_valid = 1'b1; in_res = r; in_op = o;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_res = '0; in_op = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_err); end
    checks++; if (out_res !== 4'h0 || out_op !== 3'd0) begin errors++; $display("FAIL reset_head got res %h op %0d exp 0 0", out_res, out_op); end
    checks++; if (out_zero !== 1'b0 || out_neg !== 1'b0) begin errors++; $display("FAIL reset_flags got z%b n%b exp 0 0", out_zero, out_neg); end
  endtask

  task automatic test_single();
    push(4'b1010, 3'd5);
    checks++; if (out_valid !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL single_valid got v%b c%0d exp v1 c1", out_valid, count); end
    checks++; if (out_res !== 4'b1010 || out_op !== 3'd5) begin errors++; $display("FAIL single_head got res %b op %0d exp 1010 5", out_res, out_op); end
    checks++; if (out_neg !== FLAGS || out_zero !== 1'b0) begin errors++; $display("FAIL single_flags got z%b n%b exp z0 n%b", out_zero, out_neg, FLAGS); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL single_pop got v%b c%0d exp v0 c0", out_valid, count); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 1; i <= 4; i++) push(4'(i), 3'(i));
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got c%0d rdy%b exp c4 rdy0", count, in_ready); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b exp 0", ovf_err); end
    push(4'h5, 3'd5);
    checks++; if (ovf_err !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fill_ovf got ovf%b c%0d exp ovf1 c4", ovf_err, count); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_res !== 4'(i) || out_op !== 3'(i)) begin errors++; $display("FAIL drain_%0d got v%b res %h op %0d exp v1 res %h op %0d", i, out_valid, out_res, out_op, i, i); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got c%0d v%b exp c0 v0", count, out_valid); end
    push(4'h6, 3'd6); push(4'h7, 3'd7);
    for (int i = 6; i <= 7; i++) begin
      checks++; if (out_res !== 4'(i) || out_op !== 3'(i)) begin errors++; $display("FAIL wrap_%0d got res %h op %0d exp %h %0d", i, out_res, out_op, i, i); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_err); end
  endtask

  task automatic test_simul();
    push(4'h8, 3'd1); push(4'h9, 3'd2);
    in_valid = 1'b1; in_res = 4'h0; in_op = 3'd3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd2 || out_res !== 4'h9 || out_op !== 3'd2) begin errors++; $display("FAIL simul_a got c%0d res %h op %0d exp c2 res 9 op 2", count, out_res, out_op); end
    checks++; if (out_neg !== FLAGS || out_zero !== 1'b0) begin errors++; $display("FAIL simul_flags9 got z%b n%b exp z0 n%b", out_zero, out_neg, FLAGS); end
    tick();
    checks++; if (count !== 3'd1 || out_res !== 4'h0 || out_op !== 3'd3) begin errors++; $display("FAIL simul_b got c%0d res %h op %0d exp c1 res 0 op 3", count, out_res, out_op); end
    checks++; if (out_zero !== FLAGS || out_neg !== 1'b0) begin errors++; $display("FAIL simul_zero got z%b n%b exp z%b n0", out_zero, out_neg, FLAGS); end
    tick(); out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL simul_empty got c%0d exp 0", count); end
  endtask

  task automatic test_full_pop();
    logic [3:0] exp_res [4];
    logic [2:0] exp_op  [4];
    exp_res[0] = 4'hD; exp_res[1] = 4'hE; exp_res[2] = 4'hF; exp_res[3] = 4'h2;
    exp_op[0]  = 3'd5; exp_op[1]  = 3'd6; exp_op[2]  = 3'd7; exp_op[3]  = 3'd0;
    push(4'hC, 3'd4); push(4'hD, 3'd5); push(4'hE, 3'd6); push(4'hF, 3'd7);
    in_valid = 1'b1; in_res = 4'h2; in_op = 3'd0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_a got c%0d rdy%b exp c3 rdy1", count, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_b got c%0d exp 4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_res !== exp_res[i] || out_op !== exp_op[i]) begin errors++; $display("FAIL fullpop_order%0d got res %h op %0d exp %h %0d", i, out_res, out_op, exp_res[i], exp_op[i]); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    push(4'h1, 3'd1); push(4'h3, 3'd2); push(4'h5, 3'd3);
    checks++; if (count !== 3'd3 || ovf_err !== 1'b1) begin errors++; $display("FAIL midrst_pre got c%0d ovf%b exp c3 ovf1", count, ovf_err); end
    rst = 1'b1; in_valid = 1'b1; in_res = 4'hB; in_op = 3'd6;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0 || ovf_err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst got c%0d ovf%b v%b exp c0 ovf0 v0", count, ovf_err, out_valid); end
    checks++; if (out_res !== 4'h0 || out_op !== 3'd0) begin errors++; $display("FAIL midrst_nowrite got res %h op %0d exp 0 0", out_res, out_op); end
    push(4'hA, 3'd4);
    checks++; if (count !== 3'd1 || out_res !== 4'hA || out_op !== 3'd4) begin errors++; $display("FAIL midrst_after got c%0d res %h op %0d exp c1 A 4", count, out_res, out_op); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_simul();
    test_full_pop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
